// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: multi-cycle binary-to-BCD converter (double dabble).
// One ADD3 correction pass over all BCD digits and one left shift per clock.
// The conversion takes BIN_W shift steps. Both sides use a valid/ready handshake.
// Optional feature macro: BCD_SIGNED_EN. When it is defined, in_data is treated as
// two's complement. The magnitude is converted, and the sign appears on out_neg.
module bcd_seq_converter #(
    parameter int BIN_W      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*BCD_DIGITS-1:0] out_bcd,
`ifdef BCD_SIGNED_EN
    output logic                    out_neg,
`endif
    output logic                    busy
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned DIGIT_RANGE = pow10(BCD_DIGITS);
    localparam longint unsigned BIN_RANGE   = 64'd1 << BIN_W;

    // Refuse to build a converter whose digits cannot hold the largest input.
    generate
        if (DIGIT_RANGE <= BIN_RANGE) begin : g_range_check
            $error("bcd_seq_converter: 10**BCD_DIGITS must exceed 2**BIN_W");
        end
    endgenerate

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] corrected_bcd;
    logic [BCD_W-1:0] shifted_bcd;
    logic [BIN_W-1:0] load_value;

    // Select the value that goes into the binary shift register at accept time.
    always_comb begin
`ifdef BCD_SIGNED_EN
        // Negating in BIN_W bits is enough. The most negative input wraps to itself,
        // which is exactly its positive magnitude when read as unsigned.
        load_value = in_data[BIN_W-1] ? (~in_data + 1'b1) : in_data;
`else
        load_value = in_data;
`endif
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        corrected_bcd = bcd_sr;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5)
                corrected_bcd[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
        end
        shifted_bcd = {corrected_bcd[BCD_W-2:0], bin_sr[BIN_W-1]};
    end

    // Control FSM, shift registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
`ifdef BCD_SIGNED_EN
            out_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        bin_sr   <= load_value;
                        bcd_sr   <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
`ifdef BCD_SIGNED_EN
                        out_neg  <= in_data[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    bcd_sr <= shifted_bcd;
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        out_bcd   <= shifted_bcd;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Testbench for bcd_seq_converter (BIN_W=8, BCD_DIGITS=3).
// A decimal-arithmetic reference model gives the expected BCD values.
// The signed cases are present only when BCD_SIGNED_EN is defined.
module tb_bcd_seq_converter;

    localparam int BIN_W      = 8;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BIN_W-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BCD_W-1:0] out_bcd;
    logic             busy;
`ifdef BCD_SIGNED_EN
    logic             out_neg;
`endif

    int tests = 0;
    int fails = 0;

    bcd_seq_converter #(.BIN_W(BIN_W), .BCD_DIGITS(BCD_DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
`ifdef BCD_SIGNED_EN
        .out_neg   (out_neg),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: decimal digits by repeated division.
    function automatic logic [BCD_W-1:0] to_bcd(input int value);
        logic [BCD_W-1:0] r;
        int m;
        r = '0;
        m = value;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic int magnitude(input logic [BIN_W-1:0] v);
`ifdef BCD_SIGNED_EN
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
`else
        return int'(v);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present v for one accept edge. Wait for out_valid and return the edge count after accept.
    // With noise set, in_valid and in_data change randomly while the conversion runs.
    task automatic launch(input logic [BIN_W-1:0] v, input bit noise, output int lat);
        in_data  = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("accept_in_ready_low", 32'(in_ready), 32'd0);
        check("accept_busy_high", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                in_valid = 1'($urandom);
                in_data  = BIN_W'($urandom);
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    // Full conversion with out_ready held high: check latency, value and the return to idle.
    task automatic convert(input logic [BIN_W-1:0] v, input bit noise, input string tag);
        int lat;
        out_ready = 1'b1;
        launch(v, noise, lat);
        check({tag, "_latency"}, 32'(lat), 32'(BIN_W));
        check({tag, "_bcd"}, 32'(out_bcd), 32'(to_bcd(magnitude(v))));
        step();
        check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;

        // Reset state
        rst_n = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bcd", 32'(out_bcd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef BCD_SIGNED_EN
        check("rst_out_neg", 32'(out_neg), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // out_ready while idle has no effect
        out_ready = 1'b1;
        step();
        check("idle_out_ready_no_effect", 32'(out_valid), 32'd0);

        // Maximum input and back-to-back boundary values
        convert(8'd255, 1'b0, "max255");
        convert(8'd0,   1'b0, "zero");
        convert(8'd9,   1'b0, "nine");
        convert(8'd10,  1'b0, "ten");
        convert(8'd99,  1'b0, "n99");
        convert(8'd100, 1'b0, "n100");

        // Result held in DONE while out_ready is low; the new request is ignored
        out_ready = 1'b0;
        launch(8'd255, 1'b0, lat);
        check("hold_latency", 32'(lat), 32'(BIN_W));
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_bcd", 32'(out_bcd), 32'(to_bcd(magnitude(8'd255))));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_bcd_kept", 32'(out_bcd), 32'(to_bcd(magnitude(8'd255))));
        step();
        check("release_consumed_once", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a conversion
        in_data  = 8'd200;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        convert(8'd42, 1'b0, "after_abort");

        // Input noise during SHIFT must not disturb the accepted value
        convert(8'd173, 1'b1, "noise_a");
        convert(8'd58,  1'b1, "noise_b");

        // Randomized values against the decimal model
        for (int i = 0; i < 16; i++) begin
            logic [BIN_W-1:0] v;
            v = BIN_W'($urandom_range(0, 255));
            convert(v, 1'b0, "rand");
        end

`ifdef BCD_SIGNED_EN
        // Signed mode: magnitude and sign
        convert(8'h80, 1'b0, "neg128");
        check("neg128_sign", 32'(out_neg), 32'd1);
        convert(8'hFF, 1'b0, "neg1");
        check("neg1_sign", 32'(out_neg), 32'd1);
        convert(8'h7F, 1'b0, "pos127");
        check("pos127_sign", 32'(out_neg), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
